uart_rx_wfifo: RTL and testbench

- UART receiver; the receive-direction counterpart of the FIFO-fed UART transmitter.
- Deserialises 8N1 frames from the rs232_rx pin and pushes each valid byte into a write FIFO (wfifo) feeding the SDRAM write path.
- Provides start-bit glitch rejection, framing-error detection and FIFO-overflow detection.
- Shares baud parameters with the transmitter.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx_wfifo.sv | 111 +++++++++++
 tb/tb_uart_rx_wfifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_pkg                                                   |
// | Brief   : Baud timing and 8N1 frame layout shared by UART TX and RX. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;
   localparam int BAUD_END  = 5208;   // 50 MHz / 9600 baud
   localparam int BAUD_MID  = 2604;
   localparam int CNT1_END  = 10;
   localparam int START_IDX = 0;
   localparam int STOP_IDX  = 9;
   localparam int DATA_W    = 8;
endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx_sync                                               |
// | Brief   : 3-flop synchroniser for rs232_rx plus falling-edge detect. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync,
   output logic rx_fall
);
   logic r_rx_s1;
   logic r_rx_s2;
   logic r_rx_s3;

   // Stages reset to the idle-high line level so reset release never looks like a start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   assign rx_sync = r_rx_s2;
   assign rx_fall = r_rx_s3 & ~r_rx_s2;
endmodule
`default_nettype wire

// File: rtl/uart_rx_wfifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx_wfifo                                              |
// | Brief   : 8N1 UART receiver pushing good bytes into the SDRAM wfifo. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_wfifo
   import uart_pkg::*;
#(
   parameter int BAUD_END = uart_pkg::BAUD_END,
   parameter int BAUD_MID = uart_pkg::BAUD_MID,
   parameter int CNT1_END = uart_pkg::CNT1_END
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rs232_rx,
   output logic              wfifo_wr_en,
   output logic [DATA_W-1:0] wfifo_wr_data,
   input  logic              wfifo_full,
   output logic              frame_err,
   output logic              overflow
);
   localparam int CNT0_W = $clog2(BAUD_END);
   localparam int CNT1_W = $clog2(CNT1_END);

   localparam logic [CNT0_W-1:0] c_cnt0_end = CNT0_W'(BAUD_END - 1);
   localparam logic [CNT0_W-1:0] c_cnt0_mid = CNT0_W'(BAUD_MID - 1);
   localparam logic [CNT1_W-1:0] c_start    = CNT1_W'(START_IDX);
   localparam logic [CNT1_W-1:0] c_stop     = CNT1_W'(STOP_IDX);
   localparam logic [CNT1_W-1:0] c_data_lo  = CNT1_W'(START_IDX + 1);
   localparam logic [CNT1_W-1:0] c_data_hi  = CNT1_W'(START_IDX + DATA_W);

   logic              w_rx;
   logic              w_fall;
   logic              w_sample;
   logic              w_glitch;
   logic              w_stop;
   logic              r_busy;
   logic [CNT0_W-1:0] r_cnt0;
   logic [CNT1_W-1:0] r_cnt1;
   logic [DATA_W-1:0] r_shift;

   uart_rx_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx      (rs232_rx),
      .rx_sync (w_rx),
      .rx_fall (w_fall)
   );

   assign w_sample = r_busy && (r_cnt0 == c_cnt0_mid);
   assign w_glitch = w_sample && (r_cnt1 == c_start) && w_rx;
   assign w_stop   = w_sample && (r_cnt1 == c_stop);

   // Dropping busy at mid-stop lets a back-to-back start edge be caught
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (!r_busy) begin
         if (w_fall) begin
            r_busy <= 1'b1;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
         end
      end else if (w_glitch || w_stop) begin
         r_busy <= 1'b0;
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (r_cnt0 == c_cnt0_end) begin
         r_cnt0 <= '0;
         r_cnt1 <= r_cnt1 + 1'b1;
      end else begin
         r_cnt0 <= r_cnt0 + 1'b1;
      end
   end

   // LSB arrives first, so shifting in from the top leaves bit 0 in place after 8 samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
      end else if (w_sample && (r_cnt1 >= c_data_lo) && (r_cnt1 <= c_data_hi)) begin
         r_shift <= {w_rx, r_shift[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wfifo_wr_en   <= 1'b0;
         wfifo_wr_data <= '0;
         frame_err     <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         wfifo_wr_en <= 1'b0;
         frame_err   <= 1'b0;
         overflow    <= 1'b0;
         if (w_stop) begin
            if (!w_rx) begin
               frame_err <= 1'b1;
            end else if (wfifo_full) begin
               overflow <= 1'b1;
            end else begin
               wfifo_wr_en   <= 1'b1;
               wfifo_wr_data <= r_shift;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_wfifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_rx_wfifo                                           |
// | Brief   : Directed self-checking bench for uart_rx_wfifo.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_wfifo;
   localparam int BIT_T = 16;
   localparam int LAT   = 155;  // pin fall to visible wr_en, in clocks

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rs232_rx = 1'b1;
   logic       wfifo_full = 1'b0;
   logic       wfifo_wr_en;
   logic [7:0] wfifo_wr_data;
   logic       frame_err;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int wr_cnt = 0, fe_cnt = 0, ov_cnt = 0;
   int wr_cyc = 0, start_cyc = 0;
   logic [2:0] prev_ev = 3'b000;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   uart_rx_wfifo #(.BAUD_END(16), .BAUD_MID(8), .CNT1_END(10)) dut (
      .clk           (clk),
      .rst           (rst),
      .rs232_rx      (rs232_rx),
      .wfifo_wr_en   (wfifo_wr_en),
      .wfifo_wr_data (wfifo_wr_data),
      .wfifo_full    (wfifo_full),
      .frame_err     (frame_err),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Event monitor: logs strobes, flags overlap and any strobe wider than one cycle
   always @(negedge clk) begin
      logic [2:0] ev;
      if (!rst) begin
         ev = {wfifo_wr_en, frame_err, overflow};
         if (wfifo_wr_en) begin
            got_q.push_back(wfifo_wr_data);
            wr_cnt++;
            wr_cyc = cyc;
         end
         if (frame_err) fe_cnt++;
         if (overflow)  ov_cnt++;
         if ((32'(ev[2]) + 32'(ev[1]) + 32'(ev[0])) > 1) check_eq("onehot", 32'(ev), 32'b100);
         if ((ev & prev_ev) != 3'b000) check_eq("pulse_width", 32'(ev & prev_ev), 0);
         prev_ev = ev;
      end else begin
         prev_ev = 3'b000;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bit edges are displaced by up to +-jit clocks from nominal; no drift accumulates
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int jit);
      logic [9:0] bits;
      int j_prev, j, dur;
      bits   = {stop_v, b, 1'b0};
      j_prev = 0;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         rs232_rx = bits[i];
         j   = (jit > 0) ? int'($urandom_range(2 * jit, 0)) - jit : 0;
         dur = BIT_T + j - j_prev;
         j_prev = j;
         repeat (dur) @(posedge clk);
         #1;
      end
      rs232_rx = 1'b1;
   endtask

   initial begin
      int w0, f0, o0, s1, c0;
      idle(3);
      check_eq("rst_wr_en",   32'(wfifo_wr_en), 0);
      check_eq("rst_wr_data", 32'(wfifo_wr_data), 0);
      check_eq("rst_ferr",    32'(frame_err), 0);
      check_eq("rst_ovf",     32'(overflow), 0);
      rst = 1'b0;
      idle(10);

      // back-to-back 0x55, 0xA3
      w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(8'h55, 1'b1, 0);
      s1 = start_cyc;
      check_eq("b2b_latency", 32'(wr_cyc - s1), LAT);
      send_frame(8'hA3, 1'b1, 0);
      exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
      idle(20);
      check_eq("b2b_wr_cnt", 32'(wr_cnt - w0), 2);
      check_eq("b2b_data1",  32'(got_q[got_q.size()-2]), 32'h55);
      check_eq("b2b_data2",  32'(got_q[got_q.size()-1]), 32'hA3);
      check_eq("b2b_ferr",   32'(fe_cnt - f0), 0);
      check_eq("b2b_ovf",    32'(ov_cnt - o0), 0);

      // 3-clock start glitch
      w0 = wr_cnt; f0 = fe_cnt;
      @(posedge clk); #1;
      c0 = cyc;
      rs232_rx = 1'b0;
      idle(3);
      rs232_rx = 1'b1;
      idle(1);
      @(negedge clk);
      check_eq("glitch_busy_set", 32'(dut.r_busy), 1);
      idle(9);
      @(negedge clk);
      check_eq("glitch_busy_clr", 32'(dut.r_busy), 0);
      idle(30);
      check_eq("glitch_wr", 32'(wr_cnt - w0), 0);
      check_eq("glitch_ferr", 32'(fe_cnt - f0), 0);
      send_frame(8'h3C, 1'b1, 0);
      exp_q.push_back(8'h3C);
      idle(20);
      check_eq("glitch_next_cnt",  32'(wr_cnt - w0), 1);
      check_eq("glitch_next_data", 32'(wfifo_wr_data), 32'h3C);

      // framing error then recovery
      w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(8'h7E, 1'b0, 0);
      idle(20);
      check_eq("ferr_cnt", 32'(fe_cnt - f0), 1);
      check_eq("ferr_wr",  32'(wr_cnt - w0), 0);
      send_frame(8'h81, 1'b1, 0);
      exp_q.push_back(8'h81);
      idle(20);
      check_eq("ferr_next_data", 32'(wfifo_wr_data), 32'h81);

      // overflow with wfifo full
      w0 = wr_cnt; o0 = ov_cnt; f0 = fe_cnt;
      wfifo_full = 1'b1;
      send_frame(8'h12, 1'b1, 0);
      idle(20);
      wfifo_full = 1'b0;
      check_eq("ovf_cnt",  32'(ov_cnt - o0), 1);
      check_eq("ovf_wr",   32'(wr_cnt - w0), 0);
      check_eq("ovf_ferr", 32'(fe_cnt - f0), 0);
      check_eq("ovf_data_hold", 32'(wfifo_wr_data), 32'h81);

      // break: line held low for many frame times
      w0 = wr_cnt; f0 = fe_cnt;
      @(posedge clk); #1;
      rs232_rx = 1'b0;
      idle(BIT_T * 40);
      rs232_rx = 1'b1;
      idle(40);
      check_eq("break_ferr", 32'(fe_cnt - f0), 1);
      check_eq("break_wr",   32'(wr_cnt - w0), 0);
      send_frame(8'h66, 1'b1, 0);
      exp_q.push_back(8'h66);
      idle(20);
      check_eq("break_next_data", 32'(wfifo_wr_data), 32'h66);

      // reset during data bit 4 of 0xF0
      w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
      fork
         send_frame(8'hF0, 1'b1, 0);
         begin
            repeat (BIT_T * 5 + 9) @(posedge clk);
            #1 rst = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check_eq("rst_mid_wr_en", 32'(wfifo_wr_en), 0);
               check_eq("rst_mid_data",  32'(wfifo_wr_data), 0);
               check_eq("rst_mid_busy",  32'(dut.r_busy), 0);
            end
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      idle(20);
      check_eq("rst_abort_wr", 32'(wr_cnt - w0), 0);
      send_frame(8'h0F, 1'b1, 0);
      exp_q.push_back(8'h0F);
      idle(20);
      check_eq("rst_next_cnt",  32'(wr_cnt - w0), 1);
      check_eq("rst_next_data", 32'(wfifo_wr_data), 32'h0F);
      check_eq("rst_next_err",  32'((fe_cnt - f0) + (ov_cnt - o0)), 0);

      // 200 random bytes back-to-back with edge jitter
      w0 = wr_cnt; f0 = fe_cnt; o0 = ov_cnt;
      for (int k = 0; k < 200; k++) begin
         logic [7:0] b;
         b = 8'($urandom_range(255, 0));
         exp_q.push_back(b);
         send_frame(b, 1'b1, 2);
      end
      idle(40);
      check_eq("sweep_wr_cnt", 32'(wr_cnt - w0), 200);
      check_eq("sweep_errs",   32'((fe_cnt - f0) + (ov_cnt - o0)), 0);

      check_eq("total_bytes", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         check_eq($sformatf("byte_%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
